// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state, bus owner and the
// registered memory request.
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_AW  = 32;
   localparam int unsigned ARB_DW  = 32;
   localparam int unsigned ARB_BEW = ARB_DW / 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_WAIT_GNT,
      ARB_WAIT_RSP
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DM
   } arb_owner_t;

   typedef struct packed {
      logic [ARB_AW-1:0]  addr;
      logic [ARB_DW-1:0]  wdata;
      logic [ARB_BEW-1:0] be;
      logic               we;
   } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of arbitrations fetch has lost in a row.
module arb_starve_ctr #(
   parameter int unsigned STARVE_LIMIT = 4,
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic saturated
);

   logic [CW-1:0] count_q, count_d;

   // next count: clear on a fetch grant wins over any increment
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != CW'(STARVE_LIMIT))) begin
         count_d = count_q + 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign saturated = (count_q == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-ported memory bus.
// One transaction in flight; data wins unless ARB_STARVE_GUARD_EN is defined,
// in which case fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [AW-1:0]   dm_addr,
   input  logic [DW-1:0]   dm_wdata,
   input  logic [DW/8-1:0] dm_be,
   output logic            dm_gnt,
   output logic            dm_rvalid,
   output logic [DW-1:0]   dm_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata
);

   // request register is typed by the package, so widths must agree
   if (AW != ARB_AW || DW != ARB_DW) begin : g_width_check
      $error("mem_port_arbiter: AW/DW must match mem_port_arbiter_pkg");
   end
   if (STARVE_LIMIT == 0) begin : g_limit_check
      $error("mem_port_arbiter: STARVE_LIMIT must be nonzero");
   end

   arb_state_t state_q, state_d;
   arb_owner_t owner_q, owner_d;
   mem_req_t   req_q, req_d;

   logic dm_win, if_win;
   logic if_gnt_c, dm_gnt_c;
   logic if_rvalid_c, dm_rvalid_c;
   logic starve_sat;

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (dm_gnt_c && if_req),
      .clr      (if_gnt_c),
      .saturated(starve_sat)
   );
`else
   assign starve_sat = 1'b0;
`endif

   // winner selection: data priority unless fetch has been starved out
   always_comb begin
      dm_win = dm_req && !(if_req && starve_sat);
      if_win = if_req && !dm_win;
   end

   // next state, request capture, grant and response routing
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      req_d       = req_q;
      if_gnt_c    = 1'b0;
      dm_gnt_c    = 1'b0;
      if_rvalid_c = 1'b0;
      dm_rvalid_c = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (dm_win) begin
               dm_gnt_c    = 1'b1;
               req_d.addr  = dm_addr;
               req_d.wdata = dm_wdata;
               req_d.be    = dm_be;
               req_d.we    = dm_we;
               owner_d     = OWN_DM;
               state_d     = ARB_WAIT_GNT;
            end else if (if_win) begin
               if_gnt_c    = 1'b1;
               req_d.addr  = if_addr;
               req_d.wdata = '0;
               req_d.be    = '1;
               req_d.we    = 1'b0;
               owner_d     = OWN_IF;
               state_d     = ARB_WAIT_GNT;
            end
         end
         ARB_WAIT_GNT: begin
            if (mem_gnt) begin
               state_d = ARB_WAIT_RSP;
            end
         end
         ARB_WAIT_RSP: begin
            if (mem_rvalid) begin
               if_rvalid_c = (owner_q == OWN_IF);
               dm_rvalid_c = (owner_q == OWN_DM);
               owner_d     = OWN_NONE;
               state_d     = ARB_IDLE;
            end
         end
         default: begin
            owner_d = OWN_NONE;
            state_d = ARB_IDLE;
         end
      endcase
   end

   // state, owner and request registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         owner_q <= OWN_NONE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         req_q   <= req_d;
      end
   end

   // reset gates the combinational handshakes so nothing leaks while held
   always_comb begin
      if_gnt    = if_gnt_c && !reset;
      dm_gnt    = dm_gnt_c && !reset;
      if_rvalid = if_rvalid_c && !reset;
      dm_rvalid = dm_rvalid_c && !reset;
      if_rdata  = mem_rdata;
      dm_rdata  = mem_rdata;
      mem_req   = (state_q == ARB_WAIT_GNT);
      mem_we    = req_q.we;
      mem_addr  = req_q.addr;
      mem_wdata = req_q.wdata;
      mem_be    = req_q.be;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: randomized requesters and memory,
// with a transaction-level model of the bus. Honours ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned BW    = DW / 8;
   localparam int unsigned LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit Guard = 1'b1;
`else
   localparam bit Guard = 1'b0;
`endif

   logic          clk, reset;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata, dm_rdata;
   logic [BW-1:0] dm_be;
   logic          mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [BW-1:0] mem_be;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit            is_if;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } txn_t;

   txn_t txn_q[$];            // granted, not yet answered
   int   errors = 0;
   int   checks = 0;
   int   phase  = 0;          // 0 bus free, 1 presented to memory, 2 awaiting response
   int   starve = 0;          // fetch losses in a row (guard builds)
   bit   got_if, got_dm;      // actual grants seen last cycle, for requester behaviour
   int   p_if, p_dm, p_mg, p_rv, p_stray;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: model the bus one cycle at a time and compare every output
   always @(negedge clk) begin
      bit   e_if, e_dm, r_if, r_dm;
      txn_t t;
      e_if = 1'b0; e_dm = 1'b0; r_if = 1'b0; r_dm = 1'b0;
      if (reset) begin
         check("rst_ctrl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we}, 64'd0);
         check("rst_fields", {mem_addr, mem_be}, 64'd0);
         check("rst_wdata", mem_wdata, 64'd0);
         phase = 0; starve = 0; txn_q.delete(); got_if = 1'b0; got_dm = 1'b0;
      end else begin
         if (phase == 0 && (if_req || dm_req)) begin
            if (dm_req && !(Guard && if_req && starve == LIMIT)) e_dm = 1'b1;
            else e_if = 1'b1;
         end
         check("if_gnt", if_gnt, e_if);
         check("dm_gnt", dm_gnt, e_dm);
         check("mem_req", mem_req, phase == 1);
         if (phase == 1 && mem_req && txn_q.size() > 0) begin
            check("mem_we", mem_we, txn_q[0].we);
            check("mem_addr", mem_addr, txn_q[0].addr);
            check("mem_be", mem_be, txn_q[0].be);
            if (!txn_q[0].is_if) check("mem_wdata", mem_wdata, txn_q[0].wdata);
         end
         if (phase == 2 && mem_rvalid && txn_q.size() > 0) begin
            r_if = txn_q[0].is_if;
            r_dm = !txn_q[0].is_if;
         end
         check("if_rvalid", if_rvalid, r_if);
         check("dm_rvalid", dm_rvalid, r_dm);
         if (r_if) check("if_rdata", if_rdata, mem_rdata);
         if (r_dm) check("dm_rdata", dm_rdata, mem_rdata);
         got_if = if_gnt;
         got_dm = dm_gnt;
         if (e_if || e_dm) begin
            t.is_if = e_if;
            t.we    = e_if ? 1'b0 : dm_we;
            t.addr  = e_if ? if_addr : dm_addr;
            t.wdata = dm_wdata;
            t.be    = e_if ? {BW{1'b1}} : dm_be;
            txn_q.push_back(t);
            phase = 1;
            if (e_if) starve = 0;
            else if (if_req && starve < LIMIT) starve++;
         end else if (phase == 1 && mem_gnt) begin
            phase = 2;
         end else if (phase == 2 && mem_rvalid) begin
            void'(txn_q.pop_front());
            phase = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one cycle of random requesters and memory; pending requests are held until granted
   task automatic rand_cycle();
      step();
      if (!(if_req && !got_if)) begin
         if_req  = ($urandom_range(99) < p_if);
         if_addr = $urandom;
      end
      if (!(dm_req && !got_dm)) begin
         dm_req   = ($urandom_range(99) < p_dm);
         dm_we    = 1'($urandom_range(1));
         dm_addr  = $urandom;
         dm_wdata = $urandom;
         dm_be    = BW'($urandom);
      end
      mem_gnt    = ($urandom_range(99) < p_mg);
      mem_rvalid = (phase == 2) ? ($urandom_range(99) < p_rv)
                                : (phase == 0 && $urandom_range(99) < p_stray);
      mem_rdata  = $urandom;
   endtask

   task automatic rand_run(input int pi, input int pd, input int pm, input int pr,
                           input int ps, input int n);
      p_if = pi; p_dm = pd; p_mg = pm; p_rv = pr; p_stray = ps;
      for (int i = 0; i < n; i++) rand_cycle();
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; dm_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      if_addr = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = '0;
      idle_inputs();
      repeat (3) step();
      reset = 1'b0;
      step();

      // single fetch to 0x100, memory accepts at once, data 0xDEADBEEF
      if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1; mem_rdata = 32'hDEADBEEF;
      step(); if_req = 1'b0;
      step(); mem_rvalid = 1'b1;
      step(); idle_inputs();
      step();

      // both request together: data write wins, fetch follows after IDLE
      if_req = 1'b1; if_addr = 32'h300;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h55AA; dm_be = 4'b0011;
      mem_gnt = 1'b1;
      step(); dm_req = 1'b0;
      step(); mem_rvalid = 1'b1;
      step(); mem_rvalid = 1'b0;
      step(); if_req = 1'b0;
      step(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      step(); idle_inputs();

      // memory stalls mem_gnt for 5 cycles with fetch waiting behind a data read
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h440; dm_be = 4'hF;
      step(); dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h80;
      repeat (5) step();
      mem_gnt = 1'b1;
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b1;
      step(); mem_rvalid = 1'b0;
      step(); if_req = 1'b0; mem_gnt = 1'b1;
      step(); mem_rvalid = 1'b1;
      step(); idle_inputs();

      // both requesting continuously: guard decides whether fetch ever wins
      rand_run(100, 100, 100, 100, 0, 40);
      rand_run(60, 60, 50, 50, 0, 300);
      rand_run(40, 70, 15, 30, 5, 300);

      // reset while waiting for the response, then a stray response after release
      begin
         int n;
         p_if = 100; p_dm = 50; p_mg = 100; p_rv = 0; p_stray = 0;
         n = 0;
         while (phase != 2 && n < 50) begin
            rand_cycle();
            n++;
         end
         checks++;
         if (phase != 2) begin
            errors++;
            $display("FAIL reach_wait_rsp: got phase %0d expected 2", phase);
         end
      end
      step(); reset = 1'b1; idle_inputs();
      step();
      step(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
      step(); mem_rvalid = 1'b0;
      if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1;
      step(); if_req = 1'b0;
      step(); mem_rvalid = 1'b1; mem_rdata = 32'hC0DE_0001;
      step(); idle_inputs();

      rand_run(70, 70, 60, 60, 3, 200);
      idle_inputs();
      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported memory bus between two requesters: instruction fetch (IF) and data memory access (DM).
- Sits between the pipeline's fetch/memory stages and the unified memory.
- Arbitrates with data priority, plus an optional anti-starvation guard for fetch.
- Allows one outstanding transaction at a time and sequences it through request, grant and response phases.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)
- STARVE_LIMIT, 4, consecutive lost arbitrations before fetch is forced to win (used only with the guard compiled in)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_be  in  DW/8  byte enables
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  data response (read data or write ack)
- dm_rdata  out  DW  data read data
- mem_req, mem_we, mem_addr, mem_wdata, mem_be  out  1/1/AW/DW/DW/8  memory request and its fields
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  memory response; returned for writes too
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RSP. An owner register (NONE/IF/DM) records who holds the bus.

**IDLE**
- If any request is present, pick a winner, assert its gnt combinationally and latch its fields into the request register.
- Record the owner and go to WAIT_GNT.
- Fetch requests are latched with we=0 and be=all ones.

**Winner selection**
- dm_req wins over if_req.
- Exception (guard only): fetch wins when if_req is high and the starve count equals STARVE_LIMIT.

**WAIT_GNT**
- mem_req=1, with fields driven from the request register and held stable.
- On mem_gnt go to WAIT_RSP.

**WAIT_RSP**
- mem_req=0.
- On mem_rvalid, pulse the owner's rvalid, clear the owner and go to IDLE.

**Response routing**
- if_rdata and dm_rdata are driven from mem_rdata.
- Their value is meaningful only while the matching rvalid is high.
- mem_rvalid outside WAIT_RSP is ignored.

**Boundary conditions**
- Both requests present in the same cycle: exactly one gnt, never both.
- A requester is not granted in the cycle its response returns; IDLE is always re-entered first.
- Reset mid-transaction: the in-flight transaction is dropped and the owner cleared. The memory is reset in the same domain.

**Reset values**
- mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid: 0.
- mem_addr, mem_wdata, mem_be: 0.
- State IDLE, owner NONE, starve count 0.
- gnt and rvalid outputs are forced to 0 while reset is high.

## Timing
- Cycle 0 (IDLE, req high): gnt=1.
- Cycle 1: mem_req=1.
- Response arrives one cycle after mem_gnt at the earliest (memory contract).
- Minimum latency, req to rvalid: 2 cycles when mem_gnt=1 in cycle 1.
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, WAIT_GNT, WAIT_RSP).
- mem_gnt stalls extend WAIT_GNT without limit; request fields must not change meanwhile.
- Requesters sample gnt at the rising edge; they may change req or fields in the cycle after gnt.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - The starve counter (width clog2(STARVE_LIMIT+1)) increments when DM wins in IDLE while if_req is high.
  - It saturates at STARVE_LIMIT and clears when IF is granted.
  - At saturation the next contested arbitration goes to IF.
- Not defined: strict data priority, no counter logic. Fetch can starve under continuous dm_req.

## Structure
- Shared package (alongside the pipeline register types) holds:
  - arb_state_t enum {ARB_IDLE, ARB_WAIT_GNT, ARB_WAIT_RSP}
  - arb_owner_t enum {OWN_NONE, OWN_IF, OWN_DM}
  - mem_req_t packed struct {addr, wdata, be, we}
- Sub-module arb_starve_ctr holds the saturating starve counter. It is instantiated only under ARB_STARVE_GUARD_EN.
- Request register: plain registered mem_req_t.

## Test plan
- Single fetch to 0x100, mem_gnt immediate, mem_rdata=0xDEADBEEF: if_gnt at cycle 0, mem_req at cycle 1, if_rvalid with 0xDEADBEEF at cycle 2; dm_rvalid stays 0.
- Simultaneous if_req and dm_req (write 0x55AA to 0x200, be=4'b0011): dm_gnt only; mem_we=1, mem_be=4'b0011. After the ack returns and one IDLE cycle, if_gnt=1.
- mem_gnt held low for 5 cycles: mem_req and its fields stay stable for 6 cycles; no gnt to the other requester meanwhile.
- Guard on, STARVE_LIMIT=4, both requesting continuously: DM is granted 4 times, then IF on the 5th arbitration, and the counter returns to 0.
- Guard off, same stimulus: IF is never granted while dm_req stays high.
- Reset asserted in WAIT_RSP, then a stray mem_rvalid after reset releases: outputs go to 0 immediately; no rvalid is forwarded, and the arbiter accepts the next request normally.
